// File: rtl/instmem_loader_if.sv
// Bus between the instruction-memory loader and its surroundings: load request,
// input word stream, memory write port and status flags.
interface instmem_loader_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              start;
  logic [ADDR_W:0]   load_len;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              enable_load_ex_mem;
  logic [ADDR_W-1:0] InstExMemAddress;
  logic [DATA_W-1:0] InstExMemData1;
  logic [DATA_W-1:0] InstExMemData2;
  logic              cpu_hold;
  logic              busy;
  logic              done;

  modport master (
    output start, load_len, in_valid, in_data,
    input  in_ready, enable_load_ex_mem, InstExMemAddress, InstExMemData1,
           InstExMemData2, cpu_hold, busy, done
  );

  modport slave (
    input  start, load_len, in_valid, in_data,
    output in_ready, enable_load_ex_mem, InstExMemAddress, InstExMemData1,
           InstExMemData2, cpu_hold, busy, done
  );
endinterface

// File: rtl/instmem_loader.sv
// Loads the instruction memory from a word stream: two stream words form one
// entry, written with a one-cycle strobe at consecutive addresses from 0.
module instmem_loader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  instmem_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, GET1, GET2, WRITE, FIN} state_e;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e            r_state;
  state_e            w_next_state;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W:0]   w_len_clamped;
  logic [ADDR_W:0]   w_cnt_inc;
  logic [DATA_W-1:0] r_data1;
  logic [DATA_W-1:0] r_data2;

  assign w_len_clamped = (bus.load_len > MAX_LEN) ? MAX_LEN : bus.load_len;
  // One extra counter bit lets the 512th write be told apart from address 0.
  assign w_cnt_inc     = r_cnt + CNT_ONE;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_data1 <= '0;
      r_data2 <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE:    if (bus.start) begin
                   r_len <= w_len_clamped;
                   r_cnt <= '0;
                 end
        GET1:    if (bus.in_valid) r_data1 <= bus.in_data;
        GET2:    if (bus.in_valid) r_data2 <= bus.in_data;
        WRITE:   r_cnt <= w_cnt_inc;
        default: ;
      endcase
    end
  end

  always_comb begin
    // NOTE: defaulting the target before the case keeps this purely
    // combinational; a path that skips the assignment would infer a latch.
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next_state = (w_len_clamped == '0) ? FIN : GET1;
      GET1:    if (bus.in_valid) w_next_state = GET2;
      GET2:    if (bus.in_valid) w_next_state = WRITE;
      WRITE:   w_next_state = (w_cnt_inc == r_len) ? FIN : GET1;
      FIN:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // All outputs decode registered state, so they are glitch-free and stable
  // for the whole WRITE cycle.
  always_comb begin
    bus.in_ready           = (r_state == GET1) || (r_state == GET2);
    bus.enable_load_ex_mem = (r_state == WRITE);
    bus.busy               = (r_state != IDLE);
    bus.cpu_hold           = (r_state != IDLE);
    bus.done               = (r_state == FIN);
    bus.InstExMemAddress   = r_cnt[ADDR_W-1:0];
    bus.InstExMemData1     = r_data1;
    bus.InstExMemData2     = r_data2;
  end
endmodule
